// File: rtl/hdc_pkg.sv
// Shared definitions for the hypervector bundler datapath and the blocks that feed it.
package hdc_pkg;

    localparam int HDC_DIMENSIONS = 10000;
    localparam int HDC_NUM_HVS    = 17;
    localparam int HDC_PAR_BITS   = 10;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } bundler_stream_state_t;

    function automatic int num_slices(input int dim, input int par);
        return (dim + par - 1) / par;
    endfunction

endpackage

// File: rtl/hv_slice_mux.sv
// Combinational slice selector: picks PAR_BITS bits per channel starting at d_i,
// zero-filling past the end of the hypervector and gating disabled channels.
module hv_slice_mux
    import hdc_pkg::*;
#(
    parameter int DIMENSIONS = HDC_DIMENSIONS,
    parameter int NUM_HVS    = HDC_NUM_HVS,
    parameter int PAR_BITS   = HDC_PAR_BITS,
    parameter int DW         = $clog2(DIMENSIONS)
) (
    input  logic [NUM_HVS-1:0][DIMENSIONS-1:0] hv_i,
    input  logic [DW-1:0]                      d_i,
    input  logic [NUM_HVS-1:0]                 en_i,
    output logic [NUM_HVS-1:0][PAR_BITS-1:0]   slice_o
);

    // The right shift brings in zeros from the top, which gives the tail fill for free.
    for (genvar g = 0; g < NUM_HVS; g++) begin : g_chan
        assign slice_o[g] = PAR_BITS'(hv_i[g] >> d_i) & {PAR_BITS{en_i[g]}};
    end

endmodule

// File: rtl/bundler_slice_streamer.sv
// Streams a stable hypervector array to the bundler one PAR_BITS-wide slice set at a
// time over valid/ready, with tail masking, channel enables and start/abort/done control.
module bundler_slice_streamer
    import hdc_pkg::*;
#(
    parameter int DIMENSIONS = HDC_DIMENSIONS,
    parameter int NUM_HVS    = HDC_NUM_HVS,
    parameter int PAR_BITS   = HDC_PAR_BITS
) (
    input  logic                                clk,
    input  logic                                nrst,
    input  logic                                start,
    input  logic                                abort,
    input  logic [NUM_HVS-1:0]                  ch_en,
    input  logic [NUM_HVS-1:0][DIMENSIONS-1:0]  hv_array,
    input  logic                                bits_ready,
    output logic                                bits_valid,
    output logic [NUM_HVS-1:0][PAR_BITS-1:0]    bits_out,
    output logic [PAR_BITS-1:0]                 bits_mask,
    output logic [$clog2(DIMENSIONS)-1:0]       bits_d,
    output logic                                bits_last,
    output logic                                busy,
    output logic                                done
);

    localparam int NUM_SLICES = num_slices(DIMENSIONS, PAR_BITS);
    localparam int LAST_W     = DIMENSIONS - (NUM_SLICES - 1) * PAR_BITS;
    localparam int DW         = $clog2(DIMENSIONS);

    localparam logic [DW-1:0]       LAST_D    = DW'((NUM_SLICES - 1) * PAR_BITS);
    localparam logic [DW-1:0]       STEP      = DW'(PAR_BITS);
    localparam logic [PAR_BITS-1:0] FULL_MASK = {PAR_BITS{1'b1}};
    localparam logic [PAR_BITS-1:0] TAIL_MASK = {PAR_BITS{1'b1}} >> (PAR_BITS - LAST_W);

    bundler_stream_state_t state_q, state_d;

    logic [DW-1:0]                    d_q, d_d;
    logic [NUM_HVS-1:0]               en_q, en_d;
    logic                             valid_q, valid_d;
    logic [NUM_HVS-1:0][PAR_BITS-1:0] out_q, out_d;
    logic [PAR_BITS-1:0]              mask_q, mask_d;
    logic [DW-1:0]                    bitsd_q, bitsd_d;
    logic                             last_q, last_d;

    logic [DW-1:0]                    mux_d;
    logic [NUM_HVS-1:0]               mux_en;
    logic [NUM_HVS-1:0][PAR_BITS-1:0] mux_out;
    logic                             load, xfer, is_last, load_slice;

    // Slice 0 is loaded straight from IDLE so the first valid follows the start cycle.
    assign mux_d   = (state_q == IDLE) ? '0 : d_q;
    assign mux_en  = (state_q == IDLE) ? ch_en : en_q;
    assign load    = !valid_q || bits_ready;
    assign xfer    = valid_q && bits_ready;
    assign is_last = (mux_d == LAST_D);

    hv_slice_mux #(
        .DIMENSIONS (DIMENSIONS),
        .NUM_HVS    (NUM_HVS),
        .PAR_BITS   (PAR_BITS),
        .DW         (DW)
    ) u_mux (
        .hv_i    (hv_array),
        .d_i     (mux_d),
        .en_i    (mux_en),
        .slice_o (mux_out)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            d_q     <= '0;
            en_q    <= '0;
            valid_q <= 1'b0;
            out_q   <= '0;
            mask_q  <= '0;
            bitsd_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            en_q    <= en_d;
            valid_q <= valid_d;
            out_q   <= out_d;
            mask_q  <= mask_d;
            bitsd_q <= bitsd_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (start) state_d = is_last ? DRAIN : STREAM;
            STREAM: if (abort) state_d = IDLE;
                    else if (load && is_last) state_d = DRAIN;
            DRAIN:  if (abort) state_d = IDLE;
                    else if (xfer) state_d = DONE;
            DONE:   state_d = IDLE;
        endcase
    end

    // Abort wins over a same-cycle transfer; the output register only moves on a load.
    always_comb begin
        d_d        = d_q;
        en_d       = en_q;
        valid_d    = valid_q;
        out_d      = out_q;
        mask_d     = mask_q;
        bitsd_d    = bitsd_q;
        last_d     = last_q;
        load_slice = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    en_d       = ch_en;
                    load_slice = 1'b1;
                end
            end
            STREAM, DRAIN: begin
                if (abort) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    d_d     = '0;
                end else if (state_q == STREAM && load) begin
                    load_slice = 1'b1;
                end else if (state_q == DRAIN && xfer) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            end
            DONE: d_d = '0;
        endcase
        if (load_slice) begin
            valid_d = 1'b1;
            out_d   = mux_out;
            bitsd_d = mux_d;
            mask_d  = is_last ? TAIL_MASK : FULL_MASK;
            last_d  = is_last;
            d_d     = is_last ? mux_d : mux_d + STEP;
        end
    end

    assign bits_valid = valid_q;
    assign bits_out   = out_q;
    assign bits_mask  = mask_q;
    assign bits_d     = bitsd_q;
    assign bits_last  = last_q;
    assign busy       = (state_q == STREAM) || (state_q == DRAIN);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_bundler_slice_streamer.sv
// Directed bench for the slice streamer: a 25-bit, 3-channel instance for the
// handshake and control corners, plus a default-sized instance for the long pass.
module tb_bundler_slice_streamer;

    typedef struct {
        logic [2:0]            en;
        bit                    allOnes;
        int                    stall;
        bit                    noise;
        logic [2:0][2:0][9:0]  exp;
    } scen_t;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    logic                 startS, abortS, readyS;
    logic [2:0]           chEnS;
    logic [2:0][24:0]     hvS;
    logic                 validS, lastS, busyS, doneS;
    logic [2:0][9:0]      outS;
    logic [9:0]           maskS;
    logic [4:0]           bitsDS;

    logic                 startB, abortB, readyB;
    logic [16:0]          chEnB;
    logic [16:0][9999:0]  hvB;
    logic                 validB, lastB, busyB, doneB;
    logic [16:0][9:0]     outB;
    logic [9:0]           maskB;
    logic [13:0]          bitsDB;

    int total = 0;
    int bad   = 0;

    logic [2:0][24:0]    hvPat;
    logic [4:0]          expD[3];
    logic [9:0]          expMask[3];
    logic                expLast[3];
    logic [2:0][2:0][9:0] basePat, onesPat;
    scen_t               scens[4];

    bundler_slice_streamer #(.DIMENSIONS(25), .NUM_HVS(3), .PAR_BITS(10)) dutSmall (
        .clk(clk), .nrst(nrst), .start(startS), .abort(abortS), .ch_en(chEnS),
        .hv_array(hvS), .bits_ready(readyS), .bits_valid(validS), .bits_out(outS),
        .bits_mask(maskS), .bits_d(bitsDS), .bits_last(lastS), .busy(busyS), .done(doneS)
    );

    bundler_slice_streamer #(.DIMENSIONS(10000), .NUM_HVS(17), .PAR_BITS(10)) dutBig (
        .clk(clk), .nrst(nrst), .start(startB), .abort(abortB), .ch_en(chEnB),
        .hv_array(hvB), .bits_ready(readyB), .bits_valid(validB), .bits_out(outB),
        .bits_mask(maskB), .bits_d(bitsDB), .bits_last(lastB), .busy(busyB), .done(doneB)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // One full pass on the small instance, optionally stalling slice 1 or pulsing start while busy.
    task automatic applyStimulus(input scen_t sc);
        int k, doneCnt, doneCyc, stallLeft, lastXfer;
        k = 0; doneCnt = 0; doneCyc = -1; stallLeft = sc.stall; lastXfer = -1;
        chEnS = sc.en;
        hvS   = sc.allOnes ? '1 : hvPat;
        @(negedge clk);
        startS = 1'b1;
        readyS = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            startS = sc.noise ? (busyS || doneS) : 1'b0;
            if (cyc == 0) checkOutput("busy after start", 32'(busyS), 32'd1);
            if (doneS) begin
                doneCnt++;
                doneCyc = cyc;
            end
            readyS = 1'b1;
            if (validS && k == 1 && stallLeft > 0) begin
                readyS = 1'b0;
                stallLeft--;
            end
            if (validS) begin
                if (k < 3) begin
                    checkOutput("bits_d", 32'(bitsDS), 32'(expD[k]));
                    checkOutput("bits_mask", 32'(maskS), 32'(expMask[k]));
                    checkOutput("bits_last", 32'(lastS), 32'(expLast[k]));
                    for (int c = 0; c < 3; c++)
                        checkOutput($sformatf("bits_out s%0d c%0d", k, c), 32'(outS[c]), 32'(sc.exp[k][c]));
                end else begin
                    checkOutput("extra slice", 32'(k), 32'd3);
                end
                if (readyS) begin
                    lastXfer = cyc;
                    k++;
                end
            end
        end
        checkOutput("slice count", 32'(k), 32'd3);
        checkOutput("done pulses", 32'(doneCnt), 32'd1);
        checkOutput("done cycle", 32'(doneCyc), 32'(3 + sc.stall));
        checkOutput("done after last xfer", 32'(doneCyc), 32'(lastXfer + 1));
        startS = 1'b0;
    endtask

    initial begin
        int doneCnt, cnt, badMask, badD, badData, lastD, lastCnt;
        bit seen;

        hvPat[0] = {5'h13, 10'h15A, 10'h2A5};
        hvPat[1] = {5'h0A, 10'h30F, 10'h0F0};
        hvPat[2] = {5'h1F, 10'h001, 10'h3FF};
        expD    = '{5'd0, 5'd10, 5'd20};
        expMask = '{10'h3FF, 10'h3FF, 10'h01F};
        expLast = '{1'b0, 1'b0, 1'b1};
        basePat[0][0] = 10'h2A5; basePat[0][1] = 10'h0F0; basePat[0][2] = 10'h3FF;
        basePat[1][0] = 10'h15A; basePat[1][1] = 10'h30F; basePat[1][2] = 10'h001;
        basePat[2][0] = 10'h013; basePat[2][1] = 10'h00A; basePat[2][2] = 10'h01F;
        onesPat = '0;
        for (int s = 0; s < 3; s++) onesPat[s][1] = expMask[s];
        scens[0] = '{en: 3'b111, allOnes: 1'b0, stall: 0, noise: 1'b0, exp: basePat};
        scens[1] = '{en: 3'b111, allOnes: 1'b0, stall: 4, noise: 1'b0, exp: basePat};
        scens[2] = '{en: 3'b010, allOnes: 1'b1, stall: 0, noise: 1'b0, exp: onesPat};
        scens[3] = '{en: 3'b111, allOnes: 1'b0, stall: 0, noise: 1'b1, exp: basePat};

        nrst = 1'b0;
        startS = 1'b0; abortS = 1'b0; readyS = 1'b0; chEnS = '0; hvS = hvPat;
        startB = 1'b0; abortB = 1'b0; readyB = 1'b0; chEnB = '1;
        for (int i = 0; i < 17; i++) hvB[i] = {1000{10'h2C3}};
        chEnB[5] = 1'b0;

        #12;
        checkOutput("reset valid", 32'(validS), 32'd0);
        checkOutput("reset out", 32'(outS), 32'd0);
        checkOutput("reset mask", 32'(maskS), 32'd0);
        checkOutput("reset busy/done", 32'({busyS, doneS, lastS, bitsDS}), 32'd0);
        @(negedge clk);
        nrst = 1'b1;

        for (int i = 0; i < 4; i++) begin
            $display("[TB] scenario %0d", i);
            applyStimulus(scens[i]);
        end

        $display("[TB] abort on second transfer");
        chEnS = 3'b111; hvS = hvPat;
        @(negedge clk); startS = 1'b1; readyS = 1'b1;
        @(negedge clk); startS = 1'b0;
        checkOutput("abort slice0 d", 32'(bitsDS), 32'd0);
        @(negedge clk);
        checkOutput("abort slice1 d", 32'(bitsDS), 32'd10);
        abortS = 1'b1;
        @(negedge clk); abortS = 1'b0;
        checkOutput("abort valid", 32'(validS), 32'd0);
        checkOutput("abort busy", 32'(busyS), 32'd0);
        checkOutput("abort last", 32'(lastS), 32'd0);
        doneCnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (doneS || validS) doneCnt++;
        end
        checkOutput("abort no done", 32'(doneCnt), 32'd0);
        applyStimulus(scens[0]);

        $display("[TB] async reset mid-stream");
        @(negedge clk); startS = 1'b1; readyS = 1'b1;
        @(negedge clk); startS = 1'b0;
        @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        checkOutput("mid reset valid", 32'(validS), 32'd0);
        checkOutput("mid reset out", 32'(outS), 32'd0);
        checkOutput("mid reset ctl", 32'({busyS, doneS, lastS, maskS, bitsDS}), 32'd0);
        @(negedge clk); nrst = 1'b1;
        applyStimulus(scens[0]);

        $display("[TB] default-size pass");
        cnt = 0; badMask = 0; badD = 0; badData = 0; lastD = -1; lastCnt = 0; seen = 1'b0;
        @(negedge clk); startB = 1'b1; readyB = 1'b1;
        for (int cyc = 0; cyc < 1100 && !seen; cyc++) begin
            @(negedge clk);
            startB = 1'b0;
            if (doneB) seen = 1'b1;
            if (validB) begin
                if (maskB != 10'h3FF) badMask++;
                if (32'(bitsDB) != 32'(cnt * 10)) badD++;
                if (outB[0] != 10'h2C3 || outB[5] != 10'h000 || outB[16] != 10'h2C3) badData++;
                if (lastB) begin
                    lastD = 32'(bitsDB);
                    lastCnt++;
                end
                cnt++;
            end
        end
        checkOutput("big done seen", 32'(seen), 32'd1);
        checkOutput("big slice count", 32'(cnt), 32'd1000);
        checkOutput("big mask errors", 32'(badMask), 32'd0);
        checkOutput("big d errors", 32'(badD), 32'd0);
        checkOutput("big data errors", 32'(badData), 32'd0);
        checkOutput("big last d", 32'(lastD), 32'd9990);
        checkOutput("big last count", 32'(lastCnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
